debounced_updown_counter: RTL and testbench

Parametrised successor to the team's single-button four-bit counter for the MACH64 CPLD board. Takes raw step-up, step-down and load buttons, plus a direction switch. Each button is debounced with its own shift-register sampler clocked by an internal clock-enable prescaler. Debounced button releases step a WIDTH-bit counter synchronously in the system clock domain, with selectable wrap or saturate mode, terminal-count flag and load from switches. The block replaces the old ripple-clocked counter with a fully synchronous design.

---
 rtl/debounced_updown_counter_if.sv | 23 ++
 rtl/debounced_updown_counter.sv | 96 +++++++++
 tb/tb_debounced_updown_counter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/debounced_updown_counter_if.sv
// debounced_updown_counter_if: button/switch inputs and counter outputs of the debounced up/down counter
//   step_up_raw, step_down_raw, load_raw : raw active-low pushbuttons
//   direction  : 1 = step_up counts up, 0 = step_up counts down
//   load_value : value taken on a debounced load release
//   count, terminal, step_pulse : counter value, limit flag, change strobe
interface debounced_updown_counter_if #(parameter int WIDTH = 4);
    logic             step_up_raw;
    logic             step_down_raw;
    logic             load_raw;
    logic             direction;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             terminal;
    logic             step_pulse;
    modport master (
        output step_up_raw, step_down_raw, load_raw, direction, load_value,
        input  count, terminal, step_pulse
    );
    modport slave (
        input  step_up_raw, step_down_raw, load_raw, direction, load_value,
        output count, terminal, step_pulse
    );
endinterface

// File: rtl/debounced_updown_counter.sv
// debounced_updown_counter: debounced three-button up/down/load counter with wrap or saturate
//   clk   : system clock
//   reset : asynchronous active-low reset, released through a 2-flop synchroniser
//   bus   : slave side of debounced_updown_counter_if (raw buttons, direction, load value,
//           count, terminal, step_pulse)
module debounced_updown_counter #(
    parameter int WIDTH            = 4,
    parameter int PRESCALE_BITS    = 10,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int SATURATE         = 0
) (
    input logic                      clk,
    input logic                      reset,
    debounced_updown_counter_if.slave bus
);
    logic [1:0]               rs;
    logic                     rst_n;
    logic [3:0]               s1, s2;
    logic [PRESCALE_BITS-1:0] pre;
    logic                     tick;
    logic [2:0]               rel;
    logic                     d, step, go_up, last_up, last_up_n;
    logic [WIDTH-1:0]         cnt, nxt_cnt;
    logic                     terminal, step_pulse;

    // Assertion is immediate through the async clear of rs; release is synchronised.
    always_ff @(posedge clk or negedge reset)
        if (!reset) rs <= '0;
        else        rs <= {rs[0], 1'b1};
    assign rst_n = rs[1];

    // {direction, load, down, up}; buttons idle high (released), direction defaults to up.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= {bus.direction, bus.load_raw, bus.step_down_raw, bus.step_up_raw};
            s2 <= s1;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pre <= '0;
        else        pre <= pre + 1'b1;
    assign tick = &pre;

    // rel[0]=up, rel[1]=down, rel[2]=load; each strobes once on a stable 0->1 (release).
    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [DEBOUNCE_SAMPLES-1:0] sh, nxt;
        logic                        st, r;
        assign nxt = {sh[DEBOUNCE_SAMPLES-2:0], s2[i]};
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                sh <= '1;
                st <= 1'b1;
                r  <= 1'b0;
            end else begin
                r <= tick && (&nxt) && !st;
                if (tick) begin
                    sh <= nxt;
                    st <= (&nxt) ? 1'b1 : (~|nxt) ? 1'b0 : st;
                end
            end
        assign rel[i] = r;
    end

    assign d = s2[3];

    // Load wins over steps; simultaneous up and down releases cancel out.
    always_comb begin
        step      = rel[0] ^ rel[1];
        go_up     = rel[0] ? d : !d;
        nxt_cnt   = rel[2] ? bus.load_value :
                    !step  ? cnt :
                    go_up  ? (((&cnt) && SATURATE != 0) ? cnt : cnt + 1'b1) :
                             (((~|cnt) && SATURATE != 0) ? cnt : cnt - 1'b1);
        last_up_n = (!rel[2] && step) ? go_up : last_up;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt        <= '0;
            step_pulse <= 1'b0;
            terminal   <= 1'b0;
            last_up    <= 1'b1;
        end else begin
            cnt        <= nxt_cnt;
            step_pulse <= nxt_cnt != cnt;
            terminal   <= last_up_n ? (&nxt_cnt) : (~|nxt_cnt);
            last_up    <= last_up_n;
        end

    assign bus.count      = cnt;
    assign bus.terminal   = terminal;
    assign bus.step_pulse = step_pulse;
endmodule

// File: tb/tb_debounced_updown_counter.sv
// tb_debounced_updown_counter: directed checks of a wrapping and a saturating counter driven in parallel
module tb_debounced_updown_counter;
    localparam int W = 4;
    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       up_raw = 1'b1, dn_raw = 1'b1, ld_raw = 1'b1, dir = 1'b1;
    logic [W-1:0] lv = '0;
    int         checks = 0, failures = 0;
    int         pw = 0, ps = 0;

    always #5 clk = ~clk;

    debounced_updown_counter_if #(.WIDTH(W)) ifw ();
    debounced_updown_counter_if #(.WIDTH(W)) ifs ();

    assign ifw.step_up_raw = up_raw;
    assign ifw.step_down_raw = dn_raw;
    assign ifw.load_raw = ld_raw;
    assign ifw.direction = dir;
    assign ifw.load_value = lv;
    assign ifs.step_up_raw = up_raw;
    assign ifs.step_down_raw = dn_raw;
    assign ifs.load_raw = ld_raw;
    assign ifs.direction = dir;
    assign ifs.load_value = lv;

    debounced_updown_counter #(.WIDTH(W), .PRESCALE_BITS(2), .DEBOUNCE_SAMPLES(4), .SATURATE(0))
        dut_w (.clk(clk), .reset(reset), .bus(ifw.slave));
    debounced_updown_counter #(.WIDTH(W), .PRESCALE_BITS(2), .DEBOUNCE_SAMPLES(4), .SATURATE(1))
        dut_s (.clk(clk), .reset(reset), .bus(ifs.slave));

    always @(posedge clk) begin
        if (ifw.step_pulse) pw <= pw + 1;
        if (ifs.step_pulse) ps <= ps + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the selected buttons low for 8 ticks, release for 8 ticks, then settle.
    task automatic press(input logic u, input logic dn, input logic l);
        up_raw = !u;
        dn_raw = !dn;
        ld_raw = !l;
        cyc(8 * T);
        up_raw = 1'b1;
        dn_raw = 1'b1;
        ld_raw = 1'b1;
        cyc(8 * T + 8);
    endtask

    task automatic both(input string tag, input int cw, input int tw, input int pwx,
                        input int cs, input int ts, input int psx);
        check({tag, " count_w"}, int'(ifw.count), cw);
        check({tag, " term_w"}, int'(ifw.terminal), tw);
        check({tag, " pulses_w"}, pw, pwx);
        check({tag, " count_s"}, int'(ifs.count), cs);
        check({tag, " term_s"}, int'(ifs.terminal), ts);
        check({tag, " pulses_s"}, ps, psx);
    endtask

    initial begin
        #2 reset = 1'b0;
        cyc(4);
        reset = 1'b1;
        cyc(4);
        check("reset step_pulse_w", int'(ifw.step_pulse), 0);
        both("reset", 0, 0, 0, 0, 0, 0);
        cyc(2 * T * 4);
        both("idle", 0, 0, 0, 0, 0, 0);

        dir = 1'b1;
        for (int i = 0; i < 5; i++) begin
            up_raw = 1'b0;
            cyc(T);
            up_raw = 1'b1;
            cyc(T);
        end
        up_raw = 1'b0;
        cyc(6 * T);
        up_raw = 1'b1;
        cyc(6 * T + 8);
        both("bounce", 1, 0, 1, 1, 0, 1);

        lv = 4'd15;
        press(0, 0, 1);
        both("load15", 15, 1, 2, 15, 1, 2);

        press(1, 0, 0);
        both("up_at_max", 0, 0, 3, 15, 1, 2);

        press(0, 1, 0);
        both("down", 15, 0, 4, 14, 0, 3);

        press(0, 0, 1);
        both("load15_again", 15, 0, 4, 15, 0, 4);

        dir = 1'b0;
        press(1, 0, 0);
        both("up_dir0", 14, 0, 5, 14, 0, 5);

        dir = 1'b1;
        lv = 4'd9;
        press(1, 0, 1);
        both("load_beats_step", 9, 0, 6, 9, 0, 6);

        press(0, 0, 1);
        both("load_equal", 9, 0, 6, 9, 0, 6);

        press(1, 1, 0);
        both("cancel", 9, 0, 6, 9, 0, 6);

        up_raw = 1'b0;
        cyc(2 * T);
        up_raw = 1'b1;
        cyc(10 * T);
        both("glitch", 9, 0, 6, 9, 0, 6);

        lv = 4'd7;
        press(0, 0, 1);
        both("load7", 7, 0, 7, 7, 0, 7);

        up_raw = 1'b0;
        cyc(10);
        reset = 1'b0;
        #1;
        check("midreset count_w", int'(ifw.count), 0);
        check("midreset pulse_w", int'(ifw.step_pulse), 0);
        check("midreset count_s", int'(ifs.count), 0);
        cyc(3);
        reset = 1'b1;
        cyc(2 * T * 4);
        both("held_through_reset", 0, 0, 7, 0, 0, 7);
        up_raw = 1'b1;
        cyc(8 * T + 8);
        both("release_after_reset", 1, 0, 8, 1, 0, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
